// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: pipeline sequencer for the 5-stage core; load-use, redirect, dmem-wait, debug halt/step control.
// Latency: stall/flush/bubble controls are combinational (same cycle); state, counters and timeout pulse are registered.
// Backpressure: a dmem wait freezes every stage; a load-use holds PC and IF/ID for one bubble; HALT drains older instructions.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       de_rd_i,
  input  logic             de_mem_read_i,
  input  logic             ex_redirect_i,
  input  logic             em_mem_req_i,
  input  logic             dmem_ready_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  input  logic             step_i,
  input  logic             cnt_clr_i,
  output logic             pc_stall_o,
  output logic             fd_stall_o,
  output logic             fd_flush_o,
  output logic             de_stall_o,
  output logic             de_bubble_o,
  output logic             em_stall_o,
  output logic             halted_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Wait counter only needs to reach MEM_TIMEOUT-1; the abort fires there, so it never wraps.
  localparam int              WC_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2,
    S_STEP     = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_nxt;
  logic             r_mem_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_freeze;
  logic w_lu;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_freeze  = em_mem_req_i & ~dmem_ready_i;
  assign w_rs1_hit = id_uses_rs1_i & (id_rs1_i == de_rd_i);
  assign w_rs2_hit = id_uses_rs2_i & (id_rs2_i == de_rd_i);
  // x0 is never a real destination, so a load to x0 cannot create a hazard.
  assign w_lu      = de_mem_read_i & (de_rd_i != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // Pipeline controls: freeze beats redirect beats halt-drain beats load-use; all quiet during reset.
  always_comb begin
    pc_stall_o  = 1'b0;
    fd_stall_o  = 1'b0;
    fd_flush_o  = 1'b0;
    de_stall_o  = 1'b0;
    de_bubble_o = 1'b0;
    em_stall_o  = 1'b0;
    if (!rst_i) begin
      if (w_freeze) begin
        pc_stall_o = 1'b1;
        fd_stall_o = 1'b1;
        de_stall_o = 1'b1;
        em_stall_o = 1'b1;
      end else if (ex_redirect_i) begin
        // Redirect is honoured even in HALT so an in-flight branch can drain.
        fd_flush_o  = 1'b1;
        de_bubble_o = 1'b1;
      end else if (r_state == S_HALT || w_lu) begin
        pc_stall_o  = 1'b1;
        fd_stall_o  = 1'b1;
        de_bubble_o = 1'b1;
      end
    end
  end

  // Next-state logic for the run / dmem-wait / debug halt / single-step sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_freeze) begin
          w_state_nxt = S_MEM_WAIT;
          w_wait_nxt  = '0;
        end else if (halt_req_i) begin
          w_state_nxt = S_HALT;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready_i) begin
          w_state_nxt = halt_req_i ? S_HALT : S_RUN;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt == WC_LAST) begin
          w_state_nxt   = S_HALT;
          w_wait_nxt    = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + WC_W'(1);
        end
      end
      S_HALT: begin
        if (resume_i) begin
          w_state_nxt = S_RUN;
        end else if (step_i) begin
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        // The first unstalled cycle lets exactly one instruction into ID/EX.
        if (!w_freeze && !w_lu) begin
          w_state_nxt = S_HALT;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Sequencer state, wait counter and the one-cycle timeout pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  // Saturating count of PC-stall cycles; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr_i) begin
      r_stall_cnt <= '0;
    end else if (pc_stall_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign halted_o      = (r_state == S_HALT);
  assign mem_timeout_o = r_mem_timeout;
  assign stall_cnt_o   = r_stall_cnt;

endmodule
